// File: rtl/backdoor_spi_burst_pkg.sv
// Shared types and constants for the oversampled backdoor SPI slave.
// FSM encoding, command polarity and SPI mode bit positions.
package backdoor_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam logic CMD_READ = 1'b1;

  localparam int SPI_CPOL_BIT = 1;
  localparam int SPI_CPHA_BIT = 0;

  // SCLK high and low phases must each last at least this many system clocks.
  localparam int MIN_SCLK_PHASE_CYCLES = 4;

endpackage

// File: rtl/backdoor_spi_burst_if.sv
// Register-side bus of the backdoor SPI bridge: single-cycle read/write strobes.
// Handshake: o_WR_STB / o_RD_STB are one-cycle pulses with no ready; o_ADDR and o_WDATA are stable during a strobe, i_RDATA is sampled the cycle after o_RD_STB.
interface backdoor_spi_burst_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] o_ADDR;
  logic [DATA_WIDTH-1:0] o_WDATA;
  logic                  o_WR_STB;
  logic                  o_RD_STB;
  logic [DATA_WIDTH-1:0] i_RDATA;

  modport master (
    output o_ADDR,
    output o_WDATA,
    output o_WR_STB,
    output o_RD_STB,
    input  i_RDATA
  );

  modport slave (
    input  o_ADDR,
    input  o_WDATA,
    input  o_WR_STB,
    input  o_RD_STB,
    output i_RDATA
  );
endinterface

// File: rtl/backdoor_spi_burst_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Edges are suppressed until the chain holds only post-reset samples, so reset never fakes an edge.
module backdoor_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_D,
  output logic o_Q,
  output logic o_RISE,
  output logic o_FALL
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   r_vld;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_D};
      r_prev <= r_sync[STAGES-1];
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
    end
  end

  assign o_Q    = r_sync[STAGES-1];
  assign o_RISE = r_vld[STAGES] & ~r_prev &  r_sync[STAGES-1];
  assign o_FALL = r_vld[STAGES] &  r_prev & ~r_sync[STAGES-1];

endmodule

// File: rtl/backdoor_spi_burst.sv
// Backdoor SPI slave running entirely on i_CLK: oversampled pins, CPOL/CPHA modes,
// burst read/write with address auto-increment, read prefetch and mid-field abort.
module backdoor_spi_burst
  import backdoor_spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic   i_CLK,
  input  logic   i_RST,
  input  logic   i_SCLK,
  input  logic   i_SS,
  input  logic   i_MOSI,
  output logic   o_MISO,
  output logic   o_MISO_OE,
  output logic   o_BUSY,
  output logic   o_ABORT,
  output state_t o_DBG_STATE,
  backdoor_spi_burst_if.master bus
);

  localparam logic [1:0] MODE = 2'(SPI_MODE);
  localparam logic CPOL = MODE[SPI_CPOL_BIT];
  localparam logic CPHA = MODE[SPI_CPHA_BIT];
  localparam int   CNT_W = $clog2((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
  logic w_ss, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  backdoor_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .i_CLK (i_CLK), .i_RST (i_RST), .i_D (i_SCLK),
    .o_Q (w_sclk_lvl_unused), .o_RISE (w_sclk_rise), .o_FALL (w_sclk_fall)
  );

  backdoor_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_CLK (i_CLK), .i_RST (i_RST), .i_D (i_SS),
    .o_Q (w_ss), .o_RISE (w_ss_rise), .o_FALL (w_ss_fall)
  );

  backdoor_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_CLK (i_CLK), .i_RST (i_RST), .i_D (i_MOSI),
    .o_Q (w_mosi), .o_RISE (w_mosi_rise_unused), .o_FALL (w_mosi_fall_unused)
  );

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rw;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_shift, r_wdata, r_hold, r_oshift;
  logic                  r_wr_stb, r_rd_stb, r_rd_cap, r_load_pend;
  logic                  r_miso, r_abort;
  logic                  w_lead, w_trail, w_active, w_sample, w_launch;
  logic                  w_addr_done, w_word_done, w_end, w_abort;

  // Leading edge leaves the idle (CPOL) level; CPHA picks which edge samples.
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_active    = (r_state != IDLE) && !w_ss;
  assign w_sample    = w_active && (CPHA ? w_trail : w_lead);
  assign w_launch    = w_active && (CPHA ? w_lead : w_trail);
  assign w_addr_done = (r_state == ADDR) && w_sample && (r_cnt == ADDR_LAST);
  assign w_word_done = (r_state == DATA) && w_sample && (r_cnt == DATA_LAST);
  assign w_end       = (r_state != IDLE) && w_ss_rise;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_nxt = CMD;
      CMD:     if (w_sample) w_state_nxt = ADDR;
      ADDR:    if (w_addr_done) w_state_nxt = DATA;
      DATA:    w_state_nxt = DATA;
      default: w_state_nxt = IDLE;
    endcase
    if (w_end) begin
      w_state_nxt = IDLE;
      w_abort     = (r_state == ADDR) || (r_cnt != '0);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_wdata     <= '0;
      r_hold      <= '0;
      r_oshift    <= '0;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_rd_cap    <= 1'b0;
      r_load_pend <= 1'b0;
      r_miso      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      r_rd_cap <= r_rd_stb;
      r_abort  <= w_abort;
      if (r_rd_cap) r_hold <= bus.i_RDATA;
      if (r_wr_stb) r_addr <= r_addr + 1'b1;

      if (w_sample) begin
        case (r_state)
          CMD: begin
            r_rw  <= w_mosi;
            r_cnt <= '0;
          end
          ADDR: begin
            r_addr <= {r_addr[ADDR_WIDTH-2:0], w_mosi};
            if (w_addr_done) begin
              r_cnt <= '0;
              if (r_rw == CMD_READ) begin
                r_rd_stb    <= 1'b1;
                r_load_pend <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DATA: begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], w_mosi};
            if (w_word_done) begin
              r_cnt <= '0;
              if (r_rw == CMD_READ) begin
                // Next word's read uses the incremented address in the strobe cycle.
                r_addr      <= r_addr + 1'b1;
                r_rd_stb    <= 1'b1;
                r_load_pend <= 1'b1;
              end else begin
                r_wdata  <= {r_shift[DATA_WIDTH-2:0], w_mosi};
                r_wr_stb <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_cnt <= '0;
        endcase
      end

      if (w_launch) begin
        if (r_load_pend) begin
          r_miso      <= r_hold[DATA_WIDTH-1];
          r_oshift    <= {r_hold[DATA_WIDTH-2:0], 1'b0};
          r_load_pend <= 1'b0;
        end else if ((r_state == DATA) && (r_rw == CMD_READ)) begin
          r_miso   <= r_oshift[DATA_WIDTH-1];
          r_oshift <= {r_oshift[DATA_WIDTH-2:0], 1'b0};
        end else begin
          r_miso <= 1'b0;
        end
      end

      // Frame end discards partial fields; strobes already registered still complete.
      if (w_end) begin
        r_cnt       <= '0;
        r_load_pend <= 1'b0;
        r_miso      <= 1'b0;
      end
    end
  end

  assign o_MISO       = r_miso;
  assign o_MISO_OE    = ~w_ss;
  assign o_BUSY       = (r_state != IDLE);
  assign o_ABORT      = r_abort;
  assign o_DBG_STATE  = r_state;
  assign bus.o_ADDR   = r_addr;
  assign bus.o_WDATA  = r_wdata;
  assign bus.o_WR_STB = r_wr_stb;
  assign bus.o_RD_STB = r_rd_stb;

endmodule
